// File: rtl/ddr2_reset_sequencer.sv
// ddr2_reset_sequencer: PLL reset / lock-wait / MCB calibration sequencer for the 250 MHz DDR2 domain
// clk, rst (async, active-high); mcb_clk_locked, mcb_calib_done are async and 2-FF synchronized;
// restart restarts the sequence and clears retries and fault; pll_rst, mcb_rst, user_rst, ready,
// fault, retry_count are registered; lock_loss_count is live only with DDR2_RESET_SEQ_LOCK_LOSS_COUNT_EN.
module ddr2_reset_sequencer #(
  parameter int PLL_RST_CYCLES       = 64,
  parameter int LOCK_STABLE_CYCLES   = 1024,
  parameter int LOCK_TIMEOUT_CYCLES  = 262144,
  parameter int CALIB_TIMEOUT_CYCLES = 1048576,
  parameter int MAX_RETRIES          = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mcb_clk_locked,
  input  logic       mcb_calib_done,
  input  logic       restart,
  output logic       pll_rst,
  output logic       mcb_rst,
  output logic       user_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);
  localparam int M1 = PLL_RST_CYCLES > LOCK_STABLE_CYCLES ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int M2 = LOCK_TIMEOUT_CYCLES > CALIB_TIMEOUT_CYCLES ? LOCK_TIMEOUT_CYCLES : CALIB_TIMEOUT_CYCLES;
  localparam int MX = M1 > M2 ? M1 : M2;
  localparam int CW = $clog2(MX) + 1;
  localparam int SW = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] PR_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CT_LAST = CW'(CALIB_TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] LS_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]    MR      = 4'(MAX_RETRIES);
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, LOCK_STABLE, WAIT_CALIB, RUN, FAIL, FAULT} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sc;
  logic lk_s, lk, cd_s, cd, keep, reload;
  always_ff @(posedge clk or posedge rst)
    if (rst) {lk_s, lk, cd_s, cd} <= 4'b0;
    else {lk_s, lk, cd_s, cd} <= {mcb_clk_locked, lk_s, mcb_calib_done, cd_s};
  always_comb begin
    nxt = state;
    case (state)
      PLL_RST:     nxt = cnt == PR_LAST ? WAIT_LOCK : PLL_RST;
      WAIT_LOCK:   nxt = cnt == LT_LAST ? FAIL : lk ? LOCK_STABLE : WAIT_LOCK;
      LOCK_STABLE: nxt = lk && sc == LS_LAST ? WAIT_CALIB : cnt == LT_LAST ? FAIL : lk ? LOCK_STABLE : WAIT_LOCK;
      WAIT_CALIB:  nxt = !lk ? FAIL : cd ? RUN : cnt == CT_LAST ? FAIL : WAIT_CALIB;
      RUN:         nxt = lk && cd ? RUN : FAIL;
      FAIL:        nxt = retry_count == MR ? FAULT : PLL_RST;
      default:     nxt = FAULT;
    endcase
    if (restart) nxt = PLL_RST;
  end
  // The lock timeout spans WAIT_LOCK and LOCK_STABLE, so hopping between them keeps the count.
  assign keep   = (state == WAIT_LOCK || state == LOCK_STABLE) && (nxt == WAIT_LOCK || nxt == LOCK_STABLE);
  assign reload = restart || (nxt != state && !keep);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= PLL_RST;
      cnt         <= '0;
      sc          <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      mcb_rst     <= 1'b1;
      user_rst    <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= nxt;
      cnt         <= reload ? '0 : &cnt ? cnt : cnt + 1'b1;
      sc          <= state == LOCK_STABLE && nxt == LOCK_STABLE ? sc + 1'b1 : '0;
      retry_count <= restart ? 4'd0 : state == FAIL && nxt == PLL_RST ? retry_count + 4'd1 : retry_count;
      pll_rst     <= nxt == PLL_RST || nxt == FAULT;
      mcb_rst     <= !(nxt == WAIT_CALIB || nxt == RUN);
      user_rst    <= nxt != RUN;
      ready       <= nxt == RUN;
      fault       <= nxt == FAULT;
    end
`ifdef DDR2_RESET_SEQ_LOCK_LOSS_COUNT_EN
  // Both states are only reachable with lk high, so lk low there is always a fresh 1->0 edge.
  logic lost;
  assign lost = (state == WAIT_CALIB || state == RUN) && !lk;
  always_ff @(posedge clk or posedge rst)
    if (rst) lock_loss_count <= '0;
    else if (restart) lock_loss_count <= '0;
    else if (lost && lock_loss_count != 8'hFF) lock_loss_count <= lock_loss_count + 8'd1;
`else
  assign lock_loss_count = 8'd0;
`endif
endmodule

// File: tb/tb_ddr2_reset_sequencer.sv
// tb_ddr2_reset_sequencer: directed bench with a phase-level reference model and per-cycle compare
module tb_ddr2_reset_sequencer;
  localparam int PR = 4, LS = 8, LT = 64, CT = 128, MR = 2;
`ifdef DDR2_RESET_SEQ_LOCK_LOSS_COUNT_EN
  localparam int LLE = 1;
`else
  localparam int LLE = 0;
`endif
  localparam int R = 0, L = 1, C = 2, U = 3, F = 4, X = 5;
  logic clk = 1'b0, rst = 1'b1;
  logic mcb_clk_locked = 1'b0, mcb_calib_done = 1'b0, restart = 1'b0;
  logic pll_rst, mcb_rst, user_rst, ready, fault;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;
  int tests = 0, fails = 0, n;
  int ph = R, e = 0, run = 0, rets = 0, lls = 0;
  logic p0 = 0, p1 = 0, c0 = 0, c1 = 0, lkv, cdv;

  ddr2_reset_sequencer #(
    .PLL_RST_CYCLES(PR), .LOCK_STABLE_CYCLES(LS), .LOCK_TIMEOUT_CYCLES(LT),
    .CALIB_TIMEOUT_CYCLES(CT), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .rst(rst), .mcb_clk_locked(mcb_clk_locked), .mcb_calib_done(mcb_calib_done),
    .restart(restart), .pll_rst(pll_rst), .mcb_rst(mcb_rst), .user_rst(user_rst), .ready(ready),
    .fault(fault), .retry_count(retry_count), .lock_loss_count(lock_loss_count)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, exp, exp);
    end
  endtask

  // Reference: lock phase merges WAIT_LOCK/LOCK_STABLE; success is a run of LS+1 consecutive
  // locked samples (the entry sample plus LS stable ones) before LT cycles elapse in the phase.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      ph = R; e = 0; run = 0; rets = 0; lls = 0; p0 = 0; p1 = 0; c0 = 0; c1 = 0;
    end else begin
      lkv = p1; cdv = c1; p1 = p0; c1 = c0; p0 = mcb_clk_locked; c0 = mcb_calib_done;
      if (restart) begin
        ph = R; e = 0; rets = 0; lls = 0;
      end else case (ph)
        R: begin e++; if (e == PR) begin ph = L; e = 0; run = 0; end end
        L: begin
          e++; run = lkv ? run + 1 : 0;
          if (run == LS + 1) begin ph = C; e = 0; end
          else if (e == LT) ph = F;
        end
        C: begin
          e++;
          if (!lkv) begin ph = F; lls = lls < 255 ? lls + 1 : 255; end
          else if (cdv) ph = U;
          else if (e == CT) ph = F;
        end
        U: if (!lkv || !cdv) begin ph = F; if (!lkv) lls = lls < 255 ? lls + 1 : 255; end
        F: if (rets == MR) ph = X; else begin rets++; ph = R; e = 0; end
        default: ;
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst)
      chk("cycle_outputs",
          int'({pll_rst, mcb_rst, user_rst, ready, fault, retry_count, lock_loss_count}),
          int'({ph == R || ph == X, !(ph == C || ph == U), ph != U, ph == U, ph == X, 4'(rets), 8'(LLE ? lls : 0)}));
  end

  function automatic logic sig(input int s);
    return s == 0 ? pll_rst : s == 1 ? mcb_rst : s == 2 ? user_rst : s == 3 ? ready : fault;
  endfunction

  task automatic measure(input int s, input logic v, output int cnt);
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (sig(s) != v && cnt < 1000);
  endtask

  task automatic do_reset(input logic l, input logic c);
    rst = 1'b1; mcb_clk_locked = l; mcb_calib_done = c; restart = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset(0, 0);
    measure(0, 0, n); chk("t1_pll_fall", n, 4);
    @(negedge clk); mcb_clk_locked = 1;
    measure(1, 0, n); chk("t1_mcb_fall", n, 11);
    repeat (20) @(negedge clk); mcb_calib_done = 1;
    measure(3, 1, n); chk("t1_ready_rise", n, 3);
    chk("t1_user_rst", user_rst, 0); chk("t1_retry", retry_count, 0);

    do_reset(0, 0);
    measure(0, 0, n);
    @(negedge clk); mcb_clk_locked = 1;
    repeat (5) @(negedge clk); mcb_clk_locked = 0;
    @(negedge clk); mcb_clk_locked = 1;
    measure(1, 0, n); chk("t2_mcb_fall_after_glitch", n, 11);

    do_reset(0, 0);
    measure(4, 1, n); chk("t3_fault_rise", n, 207);
    chk("t3_pll_in_fault", pll_rst, 1); chk("t3_retry_in_fault", retry_count, 2);
    @(negedge clk); restart = 1;
    @(negedge clk); restart = 0;
    chk("t3_fault_cleared", fault, 0); chk("t3_retry_cleared", retry_count, 0);
    chk("t3_pll_restart", pll_rst, 1);
    measure(0, 0, n); chk("t3_pll_hold", n, 4);

    do_reset(1, 0);
    measure(1, 0, n); chk("t4_mcb_fall", n, 13);
    measure(1, 1, n); chk("t4_calib_timeout", n, 128);
    measure(0, 1, n); chk("t4_pll_reassert", n, 1);
    chk("t4_retry", retry_count, 1);

    measure(1, 0, n); chk("t6_mcb_fall", n, 13);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_pll", pll_rst, 1); chk("t6_async_mcb", mcb_rst, 1);
    chk("t6_async_retry", retry_count, 0);
    chk("t6_async_rest", int'({user_rst, ready, fault, lock_loss_count}), int'({1'b1, 10'd0}));

    do_reset(1, 0);
    measure(1, 0, n); chk("t5_mcb_fall", n, 13);
    @(negedge clk); mcb_calib_done = 1;
    measure(3, 1, n); chk("t5_ready_rise", n, 3);
    @(negedge clk); mcb_clk_locked = 0;
    measure(2, 1, n); chk("t5_user_rst_on_loss", n, 3);
    chk("t5_ready_low", ready, 0); chk("t5_lock_loss", lock_loss_count, LLE);
    @(negedge clk); mcb_clk_locked = 1;
    measure(3, 1, n); chk("t5_rerun", n, 15);
    chk("t5_retry", retry_count, 1); chk("t5_lock_loss_kept", lock_loss_count, LLE);
    @(negedge clk); mcb_calib_done = 0;
    measure(2, 1, n); chk("t5_calib_drop", n, 3);
    chk("t5_lock_loss_calib_drop", lock_loss_count, LLE);
    measure(0, 1, n); chk("t5_pll_after_calib_drop", n, 1);
    chk("t5_retry2", retry_count, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
